// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared op/state encodings and default sizing for the load/store unit
package load_store_unit_pkg;
   localparam int ADDR_WORD_BITS_DEFAULT = 8;
   typedef enum logic [2:0] {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB} opE;
   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} stateE;
endpackage

// File: rtl/load_store_unit_lane_align.sv
// lane_align: little-endian lane extraction/extension, sub-word store merge and alignment check
module lane_align import load_store_unit_pkg::*; (
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  opE          op,
   input  logic [31:0] storeData,
   output logic [31:0] loadResult,
   output logic [31:0] mergedWord,
   output logic        misaligned
);
   logic [7:0]  laneByte;
   logic [15:0] laneHalf;
   logic [31:0] byteMask;
   logic [31:0] halfMask;
   assign laneByte = 8'(word >> {offset, 3'b000});
   assign laneHalf = offset[1] ? word[31:16] : word[15:0];
   assign byteMask = 32'h0000_00FF << {offset, 3'b000};
   assign halfMask = offset[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
   // Per-op alignment fault, extended load value and store word with only the addressed lane replaced
   always_comb begin
      misaligned = (op == OP_LW || op == OP_SW) ? |offset :
                   (op == OP_LH || op == OP_LHU || op == OP_SH) ? offset[0] : 1'b0;
      loadResult = op == OP_LW  ? word :
                   op == OP_LH  ? {{16{laneHalf[15]}}, laneHalf} :
                   op == OP_LHU ? {16'h0000, laneHalf} :
                   op == OP_LB  ? {{24{laneByte[7]}}, laneByte} :
                   op == OP_LBU ? {24'h000000, laneByte} : 32'h0;
      mergedWord = op == OP_SB ? (word & ~byteMask) | ({24'h000000, storeData[7:0]} << {offset, 3'b000}) :
                   op == OP_SH ? (word & ~halfMask) | ({16'h0000, storeData[15:0]} << {offset[1], 4'b0000}) :
                   storeData;
   end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sequences CPU loads/stores into full-word data memory transactions
module load_store_unit import load_store_unit_pkg::*; #(
   parameter int ADDR_WORD_BITS = ADDR_WORD_BITS_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic [2:0]  op,
   input  logic [31:0] byte_addr,
   input  logic [31:0] store_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] load_data,
   output logic        misaligned,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write_sign,
   output logic        mem_read_sign,
   input  logic [31:0] mem_read_data
);
   localparam logic [31:0] ADDR_MASK = 32'((64'd1 << ADDR_WORD_BITS) - 64'd1);
   stateE       state;
   stateE       nextState;
   opE          opReg;
   opE          curOp;
   logic [1:0]  offReg;
   logic [1:0]  curOff;
   logic [31:0] storeReg;
   logic [31:0] curStore;
   logic        misReg;
   logic [31:0] alignLoad;
   logic [31:0] alignMerge;
   logic        alignMis;
   logic        isIdle;
   logic        subStore;
   assign isIdle         = state == ST_IDLE;
   assign curOp          = isIdle ? opE'(op) : opReg;
   assign curOff         = isIdle ? byte_addr[1:0] : offReg;
   assign curStore       = isIdle ? store_data : storeReg;
   assign subStore       = opReg == OP_SH || opReg == OP_SB;
   assign busy           = !isIdle;
   assign done           = state == ST_DONE;
   assign misaligned     = done && misReg;
   assign mem_read_sign  = state == ST_READ;
   assign mem_write_sign = state == ST_WRITE;
   lane_align align (
      .word       (mem_read_data),
      .offset     (curOff),
      .op         (curOp),
      .storeData  (curStore),
      .loadResult (alignLoad),
      .mergedWord (alignMerge),
      .misaligned (alignMis)
   );
   // State register; reset aborts any in-flight access and drops the strobes at once
   always_ff @(posedge clock or posedge reset)
      if (reset) state <= ST_IDLE;
      else       state <= nextState;
   // Misaligned requests skip memory; sub-word stores read first so the other lanes survive
   always_comb begin
      nextState = state;
      nextState = state == ST_IDLE  ? (!req ? ST_IDLE : alignMis ? ST_DONE : curOp == OP_SW ? ST_WRITE : ST_READ) :
                  state == ST_READ  ? (subStore ? ST_WRITE : ST_DONE) :
                  state == ST_WRITE ? ST_DONE : ST_IDLE;
   end
   // Latch the request on acceptance; capture load result or merged store word at the end of READ
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         opReg          <= OP_LW;
         offReg         <= '0;
         storeReg       <= '0;
         misReg         <= 1'b0;
         load_data      <= '0;
         mem_address    <= '0;
         mem_write_data <= '0;
      end else if (isIdle && req) begin
         opReg       <= curOp;
         offReg      <= byte_addr[1:0];
         storeReg    <= store_data;
         misReg      <= alignMis;
         mem_address <= {2'b00, byte_addr[31:2]} & ADDR_MASK;
         if (alignMis) load_data <= '0;
         else if (curOp == OP_SW) mem_write_data <= alignMerge;
      end else if (state == ST_READ) begin
         if (subStore) mem_write_data <= alignMerge;
         else load_data <= alignLoad;
      end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench against a byte-array reference model
module tb_load_store_unit;
   typedef struct {
      logic [31:0] data;
      bit          mis;
      bit          chk;
      int          lat;
      int          rd;
      int          wr;
      int          issue;
   } expT;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] byte_addr = '0;
   logic [31:0] store_data = '0;
   logic        busy;
   logic        done;
   logic [31:0] load_data;
   logic        misaligned;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_write_sign;
   logic        mem_read_sign;
   logic [31:0] mem_read_data;
   logic [31:0] mem [256];
   logic [7:0]  refMem [1024];
   expT         expQ [$];
   int          cycles = 0;
   int          total = 0;
   int          passed = 0;
   int          rdCnt = 0;
   int          wrCnt = 0;

   load_store_unit dut (
      .clock          (clock),
      .reset          (reset),
      .req            (req),
      .op             (op),
      .byte_addr      (byte_addr),
      .store_data     (store_data),
      .busy           (busy),
      .done           (done),
      .load_data      (load_data),
      .misaligned     (misaligned),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_write_sign (mem_write_sign),
      .mem_read_sign  (mem_read_sign),
      .mem_read_data  (mem_read_data)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cycles++;

   assign mem_read_data = mem[mem_address[7:0]];
   always @(negedge clock) if (mem_write_sign) mem[mem_address[7:0]] <= mem_write_data;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endfunction

   function automatic logic [31:0] refWord(input int w);
      return {refMem[4*w+3], refMem[4*w+2], refMem[4*w+1], refMem[4*w]};
   endfunction

   function automatic expT model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
      expT e;
      int size = (o == 0 || o == 5) ? 4 : (o == 1 || o == 2 || o == 6) ? 2 : 1;
      int base = int'(a % 1024);
      longint v = 0;
      e.issue = cycles;
      e.mis = (base % size) != 0;
      e.chk = o < 5 || e.mis;
      e.data = 0;
      if (e.mis) begin
         e.lat = 1; e.rd = 0; e.wr = 0;
      end else if (o < 5) begin
         for (int i = 0; i < size; i++) v += longint'(refMem[base+i]) << (8*i);
         if ((o == 1 || o == 3) && v >= (64'sd1 << (8*size-1))) v -= (64'sd1 << (8*size));
         e.data = 32'(v);
         e.lat = 2; e.rd = 1; e.wr = 0;
      end else begin
         for (int i = 0; i < size; i++) refMem[base+i] = 8'(d >> (8*i));
         e.lat = size == 4 ? 2 : 3; e.rd = size == 4 ? 0 : 1; e.wr = 1;
      end
      return e;
   endfunction

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d, input bit track);
      int w = 0;
      @(negedge clock);
      while (busy && w < 40) begin
         req = 1'($urandom); op = 3'($urandom); byte_addr = $urandom; store_data = $urandom;
         w++;
         @(negedge clock);
      end
      check("idleBeforeIssue", 32'(busy), 0);
      req = 1'b1; op = o; byte_addr = a; store_data = d;
      if (track) expQ.push_back(model(o, a, d));
      @(posedge clock);
      #1 req = 1'b0;
   endtask

   always @(negedge clock) begin
      expT e;
      if (reset) begin
         rdCnt = 0; wrCnt = 0;
      end else begin
         rdCnt += int'(mem_read_sign);
         wrCnt += int'(mem_write_sign);
         if (done) begin
            if (expQ.size() == 0) check("unexpectedDone", 32'(done), 0);
            else begin
               e = expQ.pop_front();
               check("misaligned", 32'(misaligned), 32'(e.mis));
               check("latency", 32'(cycles - e.issue), 32'(e.lat));
               check("readStrobes", 32'(rdCnt), 32'(e.rd));
               check("writeStrobes", 32'(wrCnt), 32'(e.wr));
               if (e.chk) check("loadData", load_data, e.data);
            end
            rdCnt = 0; wrCnt = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      for (int i = 0; i < 1024; i++) refMem[i] = 8'($urandom);
      {refMem[15], refMem[14], refMem[13], refMem[12]} = 32'h8899AABB;
      for (int w = 0; w < 256; w++) mem[w] = refWord(w);
      #1;
      check("rstBusy", 32'(busy), 0);
      check("rstDone", 32'(done), 0);
      check("rstMisaligned", 32'(misaligned), 0);
      check("rstLoadData", load_data, 0);
      check("rstMemAddress", mem_address, 0);
      check("rstMemWriteData", mem_write_data, 0);
      check("rstWriteSign", 32'(mem_write_sign), 0);
      check("rstReadSign", 32'(mem_read_sign), 0);
      @(negedge clock);
      reset = 1'b0;
      issue(3'd0, 32'h0C, 32'h0, 1);
      issue(3'd3, 32'h0F, 32'h0, 1);
      issue(3'd4, 32'h0F, 32'h0, 1);
      issue(3'd2, 32'h0E, 32'h0, 1);
      issue(3'd1, 32'h0C, 32'h0, 1);
      issue(3'd7, 32'h0D, 32'h12, 1);
      issue(3'd0, 32'h0C, 32'h0, 1);
      issue(3'd6, 32'h0E, 32'h3456, 1);
      issue(3'd0, 32'h0C, 32'h0, 1);
      issue(3'd5, 32'h10, 32'hDEADBEEF, 1);
      issue(3'd0, 32'h10, 32'h0, 1);
      issue(3'd0, 32'h0E, 32'h0, 1);
      issue(3'd6, 32'h0D, 32'hFFFF, 1);
      issue(3'd0, 32'h0C, 32'h0, 1);
      check("word3AfterStores", mem[3], 32'h345612BB);
      check("word4AfterSw", mem[4], 32'hDEADBEEF);
      issue(3'd7, 32'h0C, 32'h77, 0);
      @(posedge clock);
      #1 check("inWriteStrobe", 32'(mem_write_sign), 1);
      reset = 1'b1;
      #1;
      check("abortWriteSign", 32'(mem_write_sign), 0);
      check("abortReadSign", 32'(mem_read_sign), 0);
      check("abortBusy", 32'(busy), 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      check("word3AfterAbort", mem[3], 32'h345612BB);
      issue(3'd0, 32'h0C, 32'h0, 1);
      for (int n = 0; n < 300; n++) begin
         a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
         issue(3'($urandom_range(0, 7)), a, $urandom, 1);
      end
      for (int w = 0; w < 16; w++) if (mem[w] !== refWord(w)) check("memImage", mem[w], refWord(w));
      for (int w = 0; w < 20 && expQ.size() != 0; w++) @(negedge clock);
      req = 1'b0;
      repeat (4) @(negedge clock);
      check("queueDrained", 32'(expQ.size()), 0);
      check("finalWord3", mem[3], refWord(3));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
